// File: rtl/paillier_task_ctrl.sv
// Paillier task sequencer: runs ENC / HADD / SMUL by driving external ME and MM engines
// over LSB-first K-bit limb streams. Define PAILLIER_TASK_TIMEOUT_EN to add a watchdog abort.
module paillier_task_ctrl #(
   parameter int unsigned K           = 128,
   parameter int unsigned N           = 32,
   parameter int unsigned TIMEOUT_W   = 20,
   localparam int unsigned AW         = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [K-1:0]  in_a_data,
   input  logic          in_a_valid,
   input  logic [K-1:0]  in_b_data,
   input  logic          in_b_valid,
   input  logic          mod_wr_en,
   input  logic [AW-1:0] mod_wr_addr,
   input  logic [K-1:0]  mod_wr_data,
   output logic          me_start,
   output logic          me_x_valid,
   output logic          me_y_valid,
   output logic [K-1:0]  me_x,
   output logic [K-1:0]  me_y,
   input  logic [K-1:0]  me_result,
   input  logic          me_valid,
   output logic          mm_start,
   output logic          mm_x_valid,
   output logic          mm_y_valid,
   output logic [K-1:0]  mm_x,
   output logic [K-1:0]  mm_y,
   input  logic [K-1:0]  mm_result,
   input  logic          mm_valid,
   output logic [K-1:0]  out_data,
   output logic          out_valid,
   output logic          out_last,
   output logic          task_done,
   output logic          task_err,
   output logic          busy
);

   // state    | meaning
   // S_IDLE   | waiting for a command, modulus writable
   // S_ERR    | one-cycle task_err pulse (illegal op or watchdog)
   // S_ENC_P1 | ME r^n and MM n*m in parallel, results into scratch
   // S_ENC_P2 | MM of scratch ME[i] x G[i], results forwarded
   // S_HADD   | MM c1 x c2, results forwarded
   // S_SMUL   | ME c^k, results forwarded
   // S_DONE   | one-cycle task_done pulse
   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_ENC_P1, S_ENC_P2, S_HADD, S_SMUL, S_DONE
   } state_t;

   localparam logic [2:0]  OP_ENC   = 3'd0;
   localparam logic [2:0]  OP_HADD  = 3'd1;
   localparam logic [2:0]  OP_SMUL  = 3'd2;
   localparam logic [AW:0] CNT_N    = (AW+1)'(N);
   localparam logic [AW:0] CNT_LAST = (AW+1)'(N-1);

   state_t state, state_nxt;

   logic [AW:0] a_cnt, b_cnt, me_cnt, mm_cnt, f_cnt;
   logic        carry;

   logic [K-1:0] mod_ram [N];
   logic [K-1:0] me_ram  [N];
   logic [K-1:0] g_ram   [N];

   logic         accept, operand_st, a_take, b_take, me_take, mm_take;
   logic         feeding, p1_done, fwd_valid, fwd_last, abort;
   logic [K-1:0] fwd_data;

`ifdef PAILLIER_TASK_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic                 working;

   assign working = (state == S_ENC_P1) || (state == S_ENC_P2) ||
                    (state == S_HADD)   || (state == S_SMUL);
   assign abort   = working && (&wd_cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd_cnt <= '0;
      else if (!working || me_valid || mm_valid || a_take || b_take)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = cmd_valid && cmd_ready;
      operand_st = (state == S_ENC_P1) || (state == S_HADD) || (state == S_SMUL);
      a_take     = operand_st && in_a_valid && (a_cnt < CNT_N);
      b_take     = operand_st && in_b_valid && (b_cnt < CNT_N);
      me_take    = me_valid && (me_cnt < CNT_N) &&
                   ((state == S_ENC_P1) || (state == S_SMUL));
      mm_take    = mm_valid && (mm_cnt < CNT_N) &&
                   ((state == S_ENC_P1) || (state == S_ENC_P2) || (state == S_HADD));
      feeding    = (state == S_ENC_P2) && (f_cnt < CNT_N);
      p1_done    = (state == S_ENC_P1) && (me_cnt == CNT_N) && (mm_cnt == CNT_N) && !abort;
      fwd_valid  = 1'b0;
      fwd_last   = 1'b0;
      fwd_data   = '0;

      if (((state == S_HADD) || (state == S_ENC_P2)) && mm_take) begin
         fwd_valid = 1'b1;
         fwd_last  = (mm_cnt == CNT_LAST);
         fwd_data  = mm_result;
      end else if ((state == S_SMUL) && me_take) begin
         fwd_valid = 1'b1;
         fwd_last  = (me_cnt == CNT_LAST);
         fwd_data  = me_result;
      end

      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_ENC:  state_nxt = S_ENC_P1;
                  OP_HADD: state_nxt = S_HADD;
                  OP_SMUL: state_nxt = S_SMUL;
                  default: state_nxt = S_ERR;
               endcase
            end
         end
         S_ERR, S_DONE: state_nxt = S_IDLE;
         S_ENC_P1:      if (p1_done) state_nxt = S_ENC_P2;
         S_ENC_P2,
         S_HADD:        if (mm_cnt == CNT_N) state_nxt = S_DONE;
         S_SMUL:        if (me_cnt == CNT_N) state_nxt = S_DONE;
         default:       state_nxt = S_IDLE;
      endcase

      if (abort)
         state_nxt = S_ERR;
   end

   // Modulus is only writable while idle so a running task sees a stable value
   always_ff @(posedge clk) begin
      if (mod_wr_en && (state == S_IDLE))
         mod_ram[mod_wr_addr] <= mod_wr_data;
      if ((state == S_ENC_P1) && me_take)
         me_ram[me_cnt[AW-1:0]] <= me_result;
      if ((state == S_ENC_P1) && mm_take)
         g_ram[mm_cnt[AW-1:0]] <= mm_result + {{(K-1){1'b0}}, carry};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_cnt  <= '0;
         b_cnt  <= '0;
         me_cnt <= '0;
         mm_cnt <= '0;
         f_cnt  <= '0;
         carry  <= 1'b0;
      end else if (accept) begin
         a_cnt  <= '0;
         b_cnt  <= '0;
         me_cnt <= '0;
         mm_cnt <= '0;
         f_cnt  <= '0;
         carry  <= 1'b1;
      end else begin
         if (a_take)  a_cnt  <= a_cnt + 1'b1;
         if (b_take)  b_cnt  <= b_cnt + 1'b1;
         if (me_take) me_cnt <= me_cnt + 1'b1;
         if (feeding) f_cnt  <= f_cnt + 1'b1;
         if (p1_done)
            mm_cnt <= '0;
         else if (mm_take)
            mm_cnt <= mm_cnt + 1'b1;
         // The "+1" ripples only through all-ones limbs; carry out of the top limb is lost
         if ((state == S_ENC_P1) && mm_take)
            carry <= carry & (&mm_result);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready  <= 1'b0;
         busy       <= 1'b0;
         task_done  <= 1'b0;
         task_err   <= 1'b0;
         me_start   <= 1'b0;
         me_x_valid <= 1'b0;
         me_y_valid <= 1'b0;
         me_x       <= '0;
         me_y       <= '0;
         mm_start   <= 1'b0;
         mm_x_valid <= 1'b0;
         mm_y_valid <= 1'b0;
         mm_x       <= '0;
         mm_y       <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         cmd_ready  <= (state_nxt == S_IDLE);
         busy       <= (state_nxt != S_IDLE);
         task_done  <= (state_nxt == S_DONE);
         task_err   <= (state_nxt == S_ERR);
         me_start   <= accept && ((cmd_op == OP_ENC) || (cmd_op == OP_SMUL));
         mm_start   <= (accept && ((cmd_op == OP_ENC) || (cmd_op == OP_HADD))) || p1_done;
         me_x_valid <= 1'b0;
         me_y_valid <= 1'b0;
         mm_x_valid <= 1'b0;
         mm_y_valid <= 1'b0;
         out_valid  <= fwd_valid;
         out_last   <= fwd_valid && fwd_last;
         if (fwd_valid)
            out_data <= fwd_data;

         case (state)
            S_ENC_P1: begin
               if (b_take) begin
                  me_x <= in_b_data;
                  me_y <= mod_ram[b_cnt[AW-1:0]];
               end
               if (a_take) begin
                  mm_x <= mod_ram[a_cnt[AW-1:0]];
                  mm_y <= in_a_data;
               end
               me_x_valid <= b_take && !abort;
               me_y_valid <= b_take && !abort;
               mm_x_valid <= a_take && !abort;
               mm_y_valid <= a_take && !abort;
            end
            S_ENC_P2: begin
               if (feeding) begin
                  mm_x <= me_ram[f_cnt[AW-1:0]];
                  mm_y <= g_ram[f_cnt[AW-1:0]];
               end
               mm_x_valid <= feeding && !abort;
               mm_y_valid <= feeding && !abort;
            end
            S_HADD: begin
               if (a_take) mm_x <= in_a_data;
               if (b_take) mm_y <= in_b_data;
               mm_x_valid <= a_take && !abort;
               mm_y_valid <= b_take && !abort;
            end
            S_SMUL: begin
               if (a_take) me_x <= in_a_data;
               if (b_take) me_y <= in_b_data;
               me_x_valid <= a_take && !abort;
               me_y_valid <= b_take && !abort;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_paillier_task_ctrl.sv
// Bench for paillier_task_ctrl (K=8, N=4): XOR-limbwise engine models, directed table,
// randomized tasks against a whole-word reference model, and reset / busy-write corner cases.
module tb_paillier_task_ctrl;
   localparam int K = 8;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] in_a_data, in_b_data;
   logic       in_a_valid, in_b_valid;
   logic       mod_wr_en;
   logic [1:0] mod_wr_addr;
   logic [7:0] mod_wr_data;
   logic       me_start, me_x_valid, me_y_valid;
   logic [7:0] me_x, me_y, me_result;
   logic       me_valid;
   logic       mm_start, mm_x_valid, mm_y_valid;
   logic [7:0] mm_x, mm_y, mm_result;
   logic       mm_valid;
   logic [7:0] out_data;
   logic       out_valid, out_last, task_done, task_err, busy;

   paillier_task_ctrl #(.K(K), .N(N), .TIMEOUT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .in_a_data(in_a_data), .in_a_valid(in_a_valid),
      .in_b_data(in_b_data), .in_b_valid(in_b_valid),
      .mod_wr_en(mod_wr_en), .mod_wr_addr(mod_wr_addr), .mod_wr_data(mod_wr_data),
      .me_start(me_start), .me_x_valid(me_x_valid), .me_y_valid(me_y_valid),
      .me_x(me_x), .me_y(me_y), .me_result(me_result), .me_valid(me_valid),
      .mm_start(mm_start), .mm_x_valid(mm_x_valid), .mm_y_valid(mm_y_valid),
      .mm_x(mm_x), .mm_y(mm_y), .mm_result(mm_result), .mm_valid(mm_valid),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .task_done(task_done), .task_err(task_err), .busy(busy)
   );

   always #5 clk = ~clk;

   logic any_out;
   assign any_out = |{cmd_ready, me_start, me_x_valid, me_y_valid, me_x, me_y,
                      mm_start, mm_x_valid, mm_y_valid, mm_x, mm_y,
                      out_data, out_valid, out_last, task_done, task_err, busy};

   // Engine models: each returns x ^ y per limb, in order, with random gaps.
   logic [7:0] me_q[$];
   logic [7:0] mm_q[$];
   bit         eng_stall = 1'b0;

   always @(posedge clk) begin
      if (me_start) me_q.delete();
      if (mm_start) mm_q.delete();
      if (me_x_valid && me_y_valid) me_q.push_back(me_x ^ me_y);
      if (mm_x_valid && mm_y_valid) mm_q.push_back(mm_x ^ mm_y);
   end

   always @(negedge clk) begin
      me_valid  = 1'b0;
      mm_valid  = 1'b0;
      me_result = 8'($urandom);
      mm_result = 8'($urandom);
      if (!eng_stall && me_q.size() != 0 && $urandom_range(0, 3) != 0) begin
         me_valid  = 1'b1;
         me_result = me_q.pop_front();
      end
      if (!eng_stall && mm_q.size() != 0 && $urandom_range(0, 3) != 0) begin
         mm_valid  = 1'b1;
         mm_result = mm_q.pop_front();
      end
   end

   // Output / pulse monitor
   logic [7:0] out_q[$];
   int         last_idx, done_cnt, err_cnt, me_st_cnt, mm_st_cnt;
   bit         done_after_last, ready_ok, prev_last, prev_done, mmx_seen;
   logic [7:0] mmx_first;

   always @(negedge clk) begin
      if (out_valid) begin
         out_q.push_back(out_data);
         if (out_last) last_idx = out_q.size() - 1;
      end
      if (task_done) begin
         done_cnt++;
         if (prev_last) done_after_last = 1'b1;
      end
      if (prev_done) ready_ok = cmd_ready;
      if (task_err) err_cnt++;
      if (me_start) me_st_cnt++;
      if (mm_start) mm_st_cnt++;
      if (mm_x_valid && !mmx_seen) begin
         mmx_first = mm_x;
         mmx_seen  = 1'b1;
      end
      prev_last = out_valid && out_last;
      prev_done = task_done;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, got, exp);
      end
   endtask

   task automatic mon_clear();
      out_q.delete();
      last_idx = -1; done_cnt = 0; err_cnt = 0; me_st_cnt = 0; mm_st_cnt = 0;
      done_after_last = 1'b0; ready_ok = 1'b0; mmx_seen = 1'b0; mmx_first = 8'h00;
   endtask

   // ENC: G = (n*m) + 1 over the whole word, out = ME ^ G; HADD/SMUL: a ^ b
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] n);
      logic [31:0] g;
      if (op == 3'd0) begin
         g = (n ^ a) + 32'd1;
         return (b ^ n) ^ g;
      end
      return a ^ b;
   endfunction

   task automatic run_task(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] n, input bit load_mod, input logic [31:0] exp,
                           input bit exp_err, input bit busy_wr, input string name);
      logic [31:0] got;
      int          exp_me, exp_mm;
      for (int c = 0; c < 100 && !cmd_ready; c++) @(negedge clk);
      check({name, " ready"}, 32'(cmd_ready), 32'd1);
      if (load_mod) begin
         for (int i = 0; i < 3; i++) begin
            mod_wr_en = 1'b1; mod_wr_addr = 2'(i); mod_wr_data = n[8*i +: 8];
            @(negedge clk);
         end
      end
      mon_clear();
      cmd_valid = 1'b1; cmd_op = op;
      mod_wr_en = load_mod; mod_wr_addr = 2'd3; mod_wr_data = n[31:24];
      @(negedge clk);
      cmd_valid = 1'b0; mod_wr_en = 1'b0;
      if (exp_err) begin
         check({name, " err_pulse"}, 32'(task_err), 32'd1);
         check({name, " ready_low"}, 32'(cmd_ready), 32'd0);
         @(negedge clk);
         check({name, " ready_back"}, 32'(cmd_ready), 32'd1);
         check({name, " err_once"}, 32'(task_err), 32'd0);
         @(negedge clk);
         check({name, " err_cnt"}, 32'(err_cnt), 32'd1);
         check({name, " no_starts"}, 32'(me_st_cnt + mm_st_cnt), 32'd0);
         return;
      end
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         in_a_valid = 1'b1; in_a_data = a[8*i +: 8];
         in_b_valid = 1'b1; in_b_data = b[8*i +: 8];
         if (busy_wr && i == 0) begin
            check({name, " busy_during_wr"}, 32'(busy), 32'd1);
            mod_wr_en = 1'b1; mod_wr_addr = 2'd0; mod_wr_data = 8'hAA;
         end
         @(negedge clk);
         in_a_valid = 1'b0; in_b_valid = 1'b0; mod_wr_en = 1'b0;
      end
      for (int c = 0; c < 400 && done_cnt == 0 && err_cnt == 0; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      got = '0;
      for (int i = 0; i < N && i < out_q.size(); i++) got[8*i +: 8] = out_q[i];
      exp_me = (op == 3'd1) ? 0 : 1;
      exp_mm = (op == 3'd0) ? 2 : ((op == 3'd1) ? 1 : 0);
      check({name, " out_count"}, 32'(out_q.size()), 32'd4);
      check({name, " out_value"}, got, exp);
      check({name, " last_idx"}, 32'(last_idx), 32'd3);
      check({name, " done_cnt"}, 32'(done_cnt), 32'd1);
      check({name, " err_cnt"}, 32'(err_cnt), 32'd0);
      check({name, " done_after_last"}, 32'(done_after_last), 32'd1);
      check({name, " ready_after_done"}, 32'(ready_ok), 32'd1);
      check({name, " me_starts"}, 32'(me_st_cnt), 32'(exp_me));
      check({name, " mm_starts"}, 32'(mm_st_cnt), 32'(exp_mm));
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, n, exp;
      bit          err;
      string       name;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b, n, n_rst;

      vecs[0] = '{3'd1, 32'h04030201, 32'h40302010, 32'h13572468, 32'h44332211, 1'b0, "hadd"};
      vecs[1] = '{3'd0, 32'h5A48A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00130000, 1'b0, "enc_carry"};
      vecs[2] = '{3'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b0, "enc_top_ovf"};
      vecs[3] = '{3'd2, 32'h12345678, 32'h0F0F0F0F, 32'h00000000, 32'h1D3B5977, 1'b0, "smul"};
      vecs[4] = '{3'd5, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, "illegal5"};
      vecs[5] = '{3'd0, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000002, 1'b0, "enc_plus1"};
      vecs[6] = '{3'd7, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, "illegal7"};

      cmd_valid = 1'b0; cmd_op = 3'd0;
      in_a_valid = 1'b0; in_a_data = 8'h00; in_b_valid = 1'b0; in_b_data = 8'h00;
      mod_wr_en = 1'b0; mod_wr_addr = 2'd0; mod_wr_data = 8'h00;
      mon_clear();
      prev_last = 1'b0; prev_done = 1'b0;

      #2 rst = 1'b1;
      #2 check("reset_outputs", 32'(any_out), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(cmd_ready), 32'd1);

      foreach (vecs[i])
         run_task(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, 1'b1, vecs[i].exp,
                  vecs[i].err, 1'b0, vecs[i].name);

      // Modulus write while busy must be dropped; the next ENC still sees limb 0 = 11
      run_task(3'd2, 32'hCAFEF00D, 32'h01020304, 32'h44332211, 1'b1,
               32'hCAFEF00D ^ 32'h01020304, 1'b0, 1'b1, "smul_busy_wr");
      run_task(3'd0, 32'h0BADBEEF, 32'h76543210, 32'h44332211, 1'b0,
               ref_model(3'd0, 32'h0BADBEEF, 32'h76543210, 32'h44332211), 1'b0, 1'b0, "enc_old_mod");
      check("enc_old_mod mm_x_first", 32'(mmx_first), 32'h11);

      for (int t = 0; t < 20; t++) begin
         op = 3'($urandom_range(0, 2));
         a = $urandom; b = $urandom; n = $urandom;
         if (op == 3'd0 && (t % 3) == 0) a = n ^ {8'($urandom), 24'hFFFFFF};
         run_task(op, a, b, n, 1'b1, ref_model(op, a, b, n), 1'b0, 1'b0, "rand");
      end

      // Reset in the middle of ENC phase 1 with stalled engines
      n_rst = 32'h89ABCDEF;
      eng_stall = 1'b1;
      for (int c = 0; c < 100 && !cmd_ready; c++) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         mod_wr_en = 1'b1; mod_wr_addr = 2'(i); mod_wr_data = n_rst[8*i +: 8];
         @(negedge clk);
      end
      mod_wr_en = 1'b0;
      mon_clear();
      cmd_valid = 1'b1; cmd_op = 3'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_a_valid = 1'b1; in_a_data = 8'(i + 1); in_b_valid = 1'b1; in_b_data = 8'(i + 7);
         @(negedge clk);
      end
      in_a_valid = 1'b0; in_b_valid = 1'b0;
      check("rst_mid busy_before", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1 check("rst_mid outputs_zero", 32'(any_out), 32'd0);
      check("rst_mid busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid no_pulses", 32'(done_cnt + err_cnt), 32'd0);
      check("rst_mid ready", 32'(cmd_ready), 32'd1);
      eng_stall = 1'b0;
      me_q.delete();
      mm_q.delete();

      // Modulus RAM keeps its contents across reset
      run_task(3'd0, 32'h11223344, 32'h55667788, n_rst, 1'b0,
               ref_model(3'd0, 32'h11223344, 32'h55667788, n_rst), 1'b0, 1'b0, "enc_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/paillier_task_ctrl.md
Name: paillier_task_ctrl

Overview:
- Parametrised task sequencer for Paillier operations on K-bit limb streams of N limbs each, LSB limb first.
- Drives an external modular-exponentiation (ME) engine and an external Montgomery-multiply (MM) engine, and buffers intermediate limbs.
- Streams final limbs out with a last marker and raises done or error strobes.
- Improvements over the previous generation:
  - Runtime-loadable modulus instead of a hard-coded one.
  - Valid/ready command handshake.
  - Full carry propagation for the "+1" encryption term.
  - Illegal-op error reporting.

Parameters:
K, 128, limb width in bits.
N, 32, limbs per operand (power of two, at least 2); AW = $clog2(N).
TIMEOUT_W, 20, watchdog counter width (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when the controller is in IDLE
cmd_op  in  3  0 = ENC, 1 = HADD, 2 = SMUL, 3..7 = illegal
in_a_data / in_a_valid  in  K / 1  operand A limb stream (ENC: m, HADD: c1, SMUL: c)
in_b_data / in_b_valid  in  K / 1  operand B limb stream (ENC: r, HADD: c2, SMUL: k)
mod_wr_en  in  1  modulus limb write strobe
mod_wr_addr  in  AW  modulus limb index
mod_wr_data  in  K  modulus limb value
me_start, me_x_valid, me_y_valid  out  1  ME engine controls
me_x, me_y  out  K  ME operand limbs
me_result / me_valid  in  K / 1  ME result limb stream
mm_start, mm_x_valid, mm_y_valid  out  1  MM engine controls
mm_x, mm_y  out  K  MM operand limbs
mm_result / mm_valid  in  K / 1  MM result limb stream
out_data / out_valid / out_last  out  K / 1 / 1  result limb stream
task_done  out  1  one-cycle pulse after the last output limb
task_err  out  1  one-cycle pulse on an illegal op or a timeout
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: every output is 0; state goes to IDLE; all counters and the carry register clear. Modulus and scratch RAMs are not reset and keep their contents across rst.
- Command accept: a command is accepted on a cycle where cmd_valid and cmd_ready are both high. Reset mid-task aborts immediately with no done or error pulse.
- Modulus writes:
  - Honoured only while IDLE; ignored while busy.
  - A write on the same cycle as command accept is honoured, and that task uses the new value.
- Illegal op: go to ERR for one cycle (task_err pulse), then IDLE. No engine start is issued.
- Common timing:
  - Engine start pulses are high for exactly the one cycle after accept.
  - Operand limbs are registered: an input limb on cycle t appears at the engine on t+1 with its valid.
  - Engine result valids beyond N in the current phase are ignored.
- ENC_P1 (ME and MM concurrent):
  - ME computes r^n: me_x = in_b, me_y = in_a is not used; me_y = modulus limb.
  - MM computes n*m: mm_x = modulus limb[addr], mm_y = in_a.
  - addr increments once per in_a_valid limb.
  - ME results go to scratch ME[0..N-1].
  - MM results go to scratch G[0..N-1] with "+1" applied:
    - carry register is initialised to 1.
    - G[i] = mm_result + carry (mod 2^K).
    - carry becomes 1 only if carry was 1 and mm_result was all-ones.
    - A carry out of limb N-1 is discarded.
  - Leave ENC_P1 when both the ME count and the MM count have reached N, in any order.
- ENC_P2:
  - Pulse mm_start, then feed mm_x = ME[i] and mm_y = G[i] for i = 0..N-1 on N consecutive cycles.
  - MM results are forwarded to out_data/out_valid one cycle later.
- HADD: MM(in_a, in_b); results forwarded to the output.
- SMUL: ME(in_a, in_b); results forwarded to the output.
- Output stream: out_last is asserted with the Nth output limb. task_done pulses on the following cycle, then the state returns to IDLE. cmd_ready rises the cycle after task_done.
- Simultaneous events: a result limb and an operand limb arriving on the same cycle are both processed.

Optional Feature:
PAILLIER_TASK_TIMEOUT_EN:
- Defined:
  - A TIMEOUT_W-bit watchdog clears on any me_valid, mm_valid, or accepted operand limb, and increments otherwise while busy.
  - On reaching all-ones: pulse task_err, drop all engine valids, return to IDLE, and produce no task_done.
- Undefined: no watchdog; a stalled engine holds busy indefinitely.

Test Plan:
- Bench uses K=8, N=4 with behavioural engine models.
- HADD, with an MM model returning a^b limbwise: c1 = 01,02,03,04 and c2 = 10,20,30,40.
  -> out = 11,22,33,44; out_last on the 4th limb; task_done pulses 1 cycle later.
- ENC carry: MM phase-1 results FF,FF,12,00.
  -> G = 00,00,13,00. With an identity MM model in P2 echoing y, out = 00,00,13,00.
- ENC top overflow: MM phase-1 results FF,FF,FF,FF.
  -> G = 00,00,00,00 (carry dropped); no error raised.
- cmd_op = 5 while IDLE.
  -> task_err pulses 1 cycle; no me_start or mm_start; cmd_ready high again 2 cycles after accept.
- mod_wr_en during a busy SMUL (write 0xAA to addr 0).
  -> modulus limb 0 unchanged; a following ENC drives the old value on mm_x.
- Assert rst mid-ENC_P1.
  -> all outputs are 0 on the same cycle; busy = 0; no done or error pulse. With PAILLIER_TASK_TIMEOUT_EN and TIMEOUT_W = 4, an engine that never responds -> task_err after 15 idle cycles.
